issue_queue: RTL and testbench

//  Age-ordered issue queue directly downstream of rename. Buffers renamed instrs, tracks source

---
 rtl/issue_queue.sv | 195 +++++++++++++++++++
 tb/tb_issue_queue.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// Age-ordered compacting issue queue: slot 0 holds the oldest renamed instruction.
// Tracks source readiness from a single wakeup bus and issues the oldest ready entry.

module issue_queue_chk #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input logic             clk_i,
    input logic             rst_i,
    input logic [CNT_W-1:0] count_i,
    input logic             in_ready_i,
    input logic             in_valid_i,
    input logic             iss_valid_i
);
    // Occupancy must stay within the queue and agree with the accept signal.
    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        count_i <= CNT_W'(DEPTH));
    a_ready_match: assert property (@(posedge clk_i) disable iff (rst_i)
        in_ready_i == (count_i < CNT_W'(DEPTH)));
    a_no_enq_full: assert property (@(posedge clk_i) disable iff (rst_i)
        (in_valid_i && !in_ready_i) |=> (count_i <= CNT_W'(DEPTH)));
    a_empty_idle: assert property (@(posedge clk_i) disable iff (rst_i)
        (count_i == {CNT_W{1'b0}}) |-> !iss_valid_i);
endmodule

module issue_queue #(
    parameter  int DEPTH  = 8,
    parameter  int PREG_W = 6,
    parameter  int PAY_W  = 32,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_rs1_v_i,
    input  logic [PREG_W-1:0] in_rs1_idx_i,
    input  logic              in_rs1_rdy_i,
    input  logic              in_rs2_v_i,
    input  logic [PREG_W-1:0] in_rs2_idx_i,
    input  logic              in_rs2_rdy_i,
    input  logic              in_rd_v_i,
    input  logic [PREG_W-1:0] in_rd_idx_i,
    input  logic [PAY_W-1:0]  in_pay_i,
    input  logic              wb_valid_i,
    input  logic [PREG_W-1:0] wb_idx_i,
    output logic              iss_valid_o,
    input  logic              iss_ready_i,
    output logic [PREG_W-1:0] iss_rs1_idx_o,
    output logic [PREG_W-1:0] iss_rs2_idx_o,
    output logic [PREG_W-1:0] iss_rd_idx_o,
    output logic              iss_rd_v_o,
    output logic [PAY_W-1:0]  iss_pay_o,
    output logic [CNT_W-1:0]  count_o
);
    logic [CNT_W-1:0]  r_count;
    logic [DEPTH-1:0]  r_rs1_rdy;
    logic [DEPTH-1:0]  r_rs2_rdy;
    logic [DEPTH-1:0]  r_rd_v;
    logic [PREG_W-1:0] r_rs1_idx [DEPTH];
    logic [PREG_W-1:0] r_rs2_idx [DEPTH];
    logic [PREG_W-1:0] r_rd_idx  [DEPTH];
    logic [PAY_W-1:0]  r_pay     [DEPTH];

    logic [CNT_W-1:0]  w_count_nxt;
    logic [CNT_W-1:0]  w_tail;
    logic [DEPTH-1:0]  w_rs1_rdy_nxt;
    logic [DEPTH-1:0]  w_rs2_rdy_nxt;
    logic [DEPTH-1:0]  w_rd_v_nxt;
    logic [PREG_W-1:0] w_rs1_idx_nxt [DEPTH];
    logic [PREG_W-1:0] w_rs2_idx_nxt [DEPTH];
    logic [PREG_W-1:0] w_rd_idx_nxt  [DEPTH];
    logic [PAY_W-1:0]  w_pay_nxt     [DEPTH];

    logic [DEPTH-1:0]  w_cand;
    logic              w_any;
    logic [IDX_W-1:0]  w_sel;
    logic              w_fire;
    logic              w_enq;
    logic              w_wb_hit;
    logic              w_in_rs1_rdy;
    logic              w_in_rs2_rdy;

    assign in_ready_o   = (r_count < CNT_W'(DEPTH));
    assign count_o      = r_count;
    assign w_enq        = in_valid_i & in_ready_o;
    assign w_fire       = w_any & iss_ready_i;
    assign w_tail       = r_count - CNT_W'(w_fire);
    assign w_count_nxt  = r_count + CNT_W'(w_enq) - CNT_W'(w_fire);
    // Physical register 0 is hardwired ready, so a wakeup of index 0 is ignored.
    assign w_wb_hit     = wb_valid_i & (wb_idx_i != {PREG_W{1'b0}});
    assign w_in_rs1_rdy = !in_rs1_v_i | in_rs1_rdy_i | (in_rs1_idx_i == {PREG_W{1'b0}})
                        | (wb_valid_i & (wb_idx_i == in_rs1_idx_i));
    assign w_in_rs2_rdy = !in_rs2_v_i | in_rs2_rdy_i | (in_rs2_idx_i == {PREG_W{1'b0}})
                        | (wb_valid_i & (wb_idx_i == in_rs2_idx_i));

    // Oldest-first select: scanning from the top leaves the lowest ready slot.
    always_comb begin
        w_cand = {DEPTH{1'b0}};
        w_any  = 1'b0;
        w_sel  = {IDX_W{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_cand[i] = (CNT_W'(i) < r_count) & r_rs1_rdy[i] & r_rs2_rdy[i];
            w_sel     = w_cand[i] ? IDX_W'(i) : w_sel;
            w_any     = w_any | w_cand[i];
        end
    end

    // Issue port is a pure function of stored state, zeroed when nothing is ready.
    always_comb begin
        iss_valid_o   = w_any;
        iss_rs1_idx_o = w_any ? r_rs1_idx[w_sel] : {PREG_W{1'b0}};
        iss_rs2_idx_o = w_any ? r_rs2_idx[w_sel] : {PREG_W{1'b0}};
        iss_rd_idx_o  = w_any ? r_rd_idx[w_sel]  : {PREG_W{1'b0}};
        iss_rd_v_o    = w_any & r_rd_v[w_sel];
        iss_pay_o     = w_any ? r_pay[w_sel]     : {PAY_W{1'b0}};
    end

    // Next entry state: compact over the issued slot, apply wakeup, then append at the tail.
    always_comb begin
        w_rs1_rdy_nxt = r_rs1_rdy;
        w_rs2_rdy_nxt = r_rs2_rdy;
        w_rd_v_nxt    = r_rd_v;
        w_rs1_idx_nxt = r_rs1_idx;
        w_rs2_idx_nxt = r_rs2_idx;
        w_rd_idx_nxt  = r_rd_idx;
        w_pay_nxt     = r_pay;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (w_fire && (IDX_W'(i) >= w_sel)) begin
                w_rs1_rdy_nxt[i] = r_rs1_rdy[i+1];
                w_rs2_rdy_nxt[i] = r_rs2_rdy[i+1];
                w_rd_v_nxt[i]    = r_rd_v[i+1];
                w_rs1_idx_nxt[i] = r_rs1_idx[i+1];
                w_rs2_idx_nxt[i] = r_rs2_idx[i+1];
                w_rd_idx_nxt[i]  = r_rd_idx[i+1];
                w_pay_nxt[i]     = r_pay[i+1];
            end else begin
                w_pay_nxt[i]     = r_pay[i];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_rs1_rdy_nxt[i] = w_rs1_rdy_nxt[i] | (w_wb_hit & (w_rs1_idx_nxt[i] == wb_idx_i));
            w_rs2_rdy_nxt[i] = w_rs2_rdy_nxt[i] | (w_wb_hit & (w_rs2_idx_nxt[i] == wb_idx_i));
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_enq && (CNT_W'(i) == w_tail)) begin
                w_rs1_rdy_nxt[i] = w_in_rs1_rdy;
                w_rs2_rdy_nxt[i] = w_in_rs2_rdy;
                w_rd_v_nxt[i]    = in_rd_v_i;
                w_rs1_idx_nxt[i] = in_rs1_idx_i;
                w_rs2_idx_nxt[i] = in_rs2_idx_i;
                w_rd_idx_nxt[i]  = in_rd_idx_i;
                w_pay_nxt[i]     = in_pay_i;
            end else begin
                w_rd_v_nxt[i]    = w_rd_v_nxt[i];
            end
        end
    end

    // State registers; flush only needs to zero the occupancy since validity is positional.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count   <= {CNT_W{1'b0}};
            r_rs1_rdy <= {DEPTH{1'b0}};
            r_rs2_rdy <= {DEPTH{1'b0}};
            r_rd_v    <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_rs1_idx[i] <= {PREG_W{1'b0}};
                r_rs2_idx[i] <= {PREG_W{1'b0}};
                r_rd_idx[i]  <= {PREG_W{1'b0}};
                r_pay[i]     <= {PAY_W{1'b0}};
            end
        end else begin
            r_count   <= flush_i ? {CNT_W{1'b0}} : w_count_nxt;
            r_rs1_rdy <= w_rs1_rdy_nxt;
            r_rs2_rdy <= w_rs2_rdy_nxt;
            r_rd_v    <= w_rd_v_nxt;
            r_rs1_idx <= w_rs1_idx_nxt;
            r_rs2_idx <= w_rs2_idx_nxt;
            r_rd_idx  <= w_rd_idx_nxt;
            r_pay     <= w_pay_nxt;
        end
    end

    issue_queue_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .count_i     (r_count),
        .in_ready_i  (in_ready_o),
        .in_valid_i  (in_valid_i),
        .iss_valid_i (iss_valid_o)
    );
endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.

module tb_issue_queue;
    localparam int DEPTH  = 8;
    localparam int PREG_W = 6;
    localparam int PAY_W  = 32;
    localparam int CNT_W  = 4;

    typedef struct {
        logic [PREG_W-1:0] rs1;
        logic              r1;
        logic [PREG_W-1:0] rs2;
        logic              r2;
        logic              rdv;
        logic [PREG_W-1:0] rd;
        logic [PAY_W-1:0]  pay;
    } ent_t;

    logic clk = 1'b0;
    logic rst_i = 1'b1, flush_i = 1'b0, in_valid_i = 1'b0, in_ready_o;
    logic in_rs1_v_i = 1'b0, in_rs1_rdy_i = 1'b0, in_rs2_v_i = 1'b0, in_rs2_rdy_i = 1'b0;
    logic in_rd_v_i = 1'b0;
    logic [PREG_W-1:0] in_rs1_idx_i = '0, in_rs2_idx_i = '0, in_rd_idx_i = '0, wb_idx_i = '0;
    logic [PAY_W-1:0]  in_pay_i = '0;
    logic wb_valid_i = 1'b0, iss_valid_o, iss_ready_i = 1'b0, iss_rd_v_o;
    logic [PREG_W-1:0] iss_rs1_idx_o, iss_rs2_idx_o, iss_rd_idx_o;
    logic [PAY_W-1:0]  iss_pay_o;
    logic [CNT_W-1:0]  count_o;

    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];

    always #5 clk = ~clk;

    issue_queue dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_rs1_v_i(in_rs1_v_i), .in_rs1_idx_i(in_rs1_idx_i), .in_rs1_rdy_i(in_rs1_rdy_i),
        .in_rs2_v_i(in_rs2_v_i), .in_rs2_idx_i(in_rs2_idx_i), .in_rs2_rdy_i(in_rs2_rdy_i),
        .in_rd_v_i(in_rd_v_i), .in_rd_idx_i(in_rd_idx_i), .in_pay_i(in_pay_i),
        .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i),
        .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
        .iss_rs1_idx_o(iss_rs1_idx_o), .iss_rs2_idx_o(iss_rs2_idx_o),
        .iss_rd_idx_o(iss_rd_idx_o), .iss_rd_v_o(iss_rd_v_o),
        .iss_pay_o(iss_pay_o), .count_o(count_o)
    );

    function automatic int m_sel();
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].r1 && mq[i].r2) return i;
        return -1;
    endfunction

    function automatic logic src_rdy(input logic v, input logic rdy, input logic [PREG_W-1:0] idx);
        return !v || rdy || (idx == 0) || (wb_valid_i && (wb_idx_i == idx));
    endfunction

    // Advance one clock; the model consumes the same inputs the DUT sees at this edge.
    task automatic tick();
        int   s;
        bit   enq;
        ent_t e;
        @(posedge clk);
        if (rst_i || flush_i) begin
            mq.delete();
        end else begin
            s   = m_sel();
            enq = in_valid_i && (mq.size() < DEPTH);
            if (s >= 0 && iss_ready_i) mq.delete(s);
            if (wb_valid_i && wb_idx_i != 0) begin
                foreach (mq[i]) begin
                    if (mq[i].rs1 == wb_idx_i) mq[i].r1 = 1'b1;
                    if (mq[i].rs2 == wb_idx_i) mq[i].r2 = 1'b1;
                end
            end
            if (enq) begin
                e.rs1 = in_rs1_idx_i; e.r1 = src_rdy(in_rs1_v_i, in_rs1_rdy_i, in_rs1_idx_i);
                e.rs2 = in_rs2_idx_i; e.r2 = src_rdy(in_rs2_v_i, in_rs2_rdy_i, in_rs2_idx_i);
                e.rdv = in_rd_v_i; e.rd = in_rd_idx_i; e.pay = in_pay_i;
                mq.push_back(e);
            end
        end
        #1;
    endtask

    task automatic set_in(input logic v, input logic r1v, input int r1, input logic r1r,
                          input logic r2v, input int r2, input logic r2r,
                          input logic rdv, input int rd, input int pay);
        in_valid_i = v;
        in_rs1_v_i = r1v; in_rs1_idx_i = PREG_W'(r1); in_rs1_rdy_i = r1r;
        in_rs2_v_i = r2v; in_rs2_idx_i = PREG_W'(r2); in_rs2_rdy_i = r2r;
        in_rd_v_i = rdv; in_rd_idx_i = PREG_W'(rd); in_pay_i = PAY_W'(pay);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        checks++;
        if ({count_o, iss_valid_o, in_ready_o} !== {4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got cnt=%0d v=%b rdy=%b exp cnt=0 v=0 rdy=1", count_o, iss_valid_o, in_ready_o);
        end
        checks++;
        if ({iss_rs1_idx_o, iss_rs2_idx_o, iss_rd_idx_o, iss_rd_v_o, iss_pay_o} !== '0) begin
            errors++;
            $display("FAIL reset_fields got rd=%0d pay=%h exp 0", iss_rd_idx_o, iss_pay_o);
        end
    endtask

    task automatic test_basic();
        set_in(1'b1, 1'b1, 5, 1'b1, 1'b0, 0, 1'b0, 1'b1, 33, 32'hA);
        tick();
        set_in(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        checks++;
        if ({iss_valid_o, iss_rd_idx_o, iss_rs1_idx_o, count_o} !== {1'b1, 6'd33, 6'd5, 4'd1}) begin
            errors++;
            $display("FAIL basic_issue got v=%b rd=%0d rs1=%0d cnt=%0d exp v=1 rd=33 rs1=5 cnt=1", iss_valid_o, iss_rd_idx_o, iss_rs1_idx_o, count_o);
        end
        iss_ready_i = 1'b1;
        tick();
        iss_ready_i = 1'b0;
        checks++;
        if ({count_o, iss_valid_o} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL basic_remove got cnt=%0d v=%b exp cnt=0 v=0", count_o, iss_valid_o);
        end
    endtask

    task automatic test_order();
        set_in(1'b1, 1'b1, 40, 1'b0, 1'b0, 0, 1'b0, 1'b1, 20, 32'hB);
        tick();
        set_in(1'b1, 1'b1, 7, 1'b1, 1'b1, 8, 1'b1, 1'b1, 21, 32'hC);
        tick();
        set_in(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        checks++;
        if ({iss_valid_o, iss_pay_o, count_o} !== {1'b1, 32'hC, 4'd2}) begin
            errors++;
            $display("FAIL order_c_first got v=%b pay=%h cnt=%0d exp v=1 pay=c cnt=2", iss_valid_o, iss_pay_o, count_o);
        end
        iss_ready_i = 1'b1;
        tick();
        iss_ready_i = 1'b0;
        checks++;
        if ({iss_valid_o, count_o} !== {1'b0, 4'd1}) begin
            errors++;
            $display("FAIL order_b_waits got v=%b cnt=%0d exp v=0 cnt=1", iss_valid_o, count_o);
        end
        wb_valid_i = 1'b1; wb_idx_i = 6'd40;
        tick();
        wb_valid_i = 1'b0;
        checks++;
        if ({iss_valid_o, iss_pay_o, iss_rs1_idx_o} !== {1'b1, 32'hB, 6'd40}) begin
            errors++;
            $display("FAIL order_b_wake got v=%b pay=%h rs1=%0d exp v=1 pay=b rs1=40", iss_valid_o, iss_pay_o, iss_rs1_idx_o);
        end
        iss_ready_i = 1'b1;
        tick();
        iss_ready_i = 1'b0;
    endtask

    task automatic test_bypass();
        set_in(1'b1, 1'b0, 0, 1'b0, 1'b1, 41, 1'b0, 1'b0, 3, 32'hD);
        wb_valid_i = 1'b1; wb_idx_i = 6'd41;
        tick();
        set_in(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        wb_valid_i = 1'b0;
        checks++;
        if ({iss_valid_o, iss_pay_o, iss_rs2_idx_o, iss_rd_v_o} !== {1'b1, 32'hD, 6'd41, 1'b0}) begin
            errors++;
            $display("FAIL bypass got v=%b pay=%h rs2=%0d rdv=%b exp v=1 pay=d rs2=41 rdv=0", iss_valid_o, iss_pay_o, iss_rs2_idx_o, iss_rd_v_o);
        end
        iss_ready_i = 1'b1;
        tick();
        iss_ready_i = 1'b0;
    endtask

    task automatic test_full();
        int exp_pay[7] = '{100, 101, 102, 104, 105, 106, 107};
        int wake[7]    = '{10, 11, 12, 14, 15, 16, 17};
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, 1'b1, 10 + i, 1'b0, 1'b0, 0, 1'b0, 1'b1, i, 100 + i);
            tick();
        end
        set_in(1'b1, 1'b1, 1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 9, 999);
        tick();
        checks++;
        if ({count_o, in_ready_o, iss_valid_o} !== {4'd8, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL full_state got cnt=%0d rdy=%b v=%b exp cnt=8 rdy=0 v=0", count_o, in_ready_o, iss_valid_o);
        end
        set_in(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        wb_valid_i = 1'b1; wb_idx_i = 6'd13;
        tick();
        wb_valid_i = 1'b0;
        checks++;
        if ({iss_valid_o, iss_pay_o} !== {1'b1, 32'd103}) begin
            errors++;
            $display("FAIL full_wake_slot3 got v=%b pay=%0d exp v=1 pay=103", iss_valid_o, iss_pay_o);
        end
        iss_ready_i = 1'b1;
        tick();
        iss_ready_i = 1'b0;
        checks++;
        if ({count_o, in_ready_o} !== {4'd7, 1'b1}) begin
            errors++;
            $display("FAIL full_after_issue got cnt=%0d rdy=%b exp cnt=7 rdy=1", count_o, in_ready_o);
        end
        foreach (wake[k]) begin
            wb_valid_i = 1'b1; wb_idx_i = PREG_W'(wake[k]);
            tick();
        end
        wb_valid_i = 1'b0;
        iss_ready_i = 1'b1;
        foreach (exp_pay[k]) begin
            checks++;
            if ({iss_valid_o, iss_pay_o} !== {1'b1, PAY_W'(exp_pay[k])}) begin
                errors++;
                $display("FAIL full_order got v=%b pay=%0d exp v=1 pay=%0d", iss_valid_o, iss_pay_o, exp_pay[k]);
            end
            tick();
        end
        iss_ready_i = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b1, 2, 1'b1, 1'b0, 0, 1'b0, 1'b1, i, 300 + i);
            tick();
        end
        checks++;
        if ({count_o, iss_valid_o} !== {4'd5, 1'b1}) begin
            errors++;
            $display("FAIL flush_pre got cnt=%0d v=%b exp cnt=5 v=1", count_o, iss_valid_o);
        end
        iss_ready_i = 1'b1; flush_i = 1'b1;
        tick();
        iss_ready_i = 1'b0; flush_i = 1'b0;
        set_in(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        checks++;
        if ({count_o, iss_valid_o, in_ready_o} !== {4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL flush_post got cnt=%0d v=%b rdy=%b exp cnt=0 v=0 rdy=1", count_o, iss_valid_o, in_ready_o);
        end
    endtask

    task automatic test_stall();
        set_in(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1, 200);
        tick();
        set_in(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 2, 201);
        tick();
        set_in(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({iss_valid_o, iss_pay_o, iss_rd_idx_o, count_o} !== {1'b1, 32'd200, 6'd1, 4'd2}) begin
                errors++;
                $display("FAIL stall_hold got v=%b pay=%0d rd=%0d cnt=%0d exp v=1 pay=200 rd=1 cnt=2", iss_valid_o, iss_pay_o, iss_rd_idx_o, count_o);
            end
            tick();
        end
        iss_ready_i = 1'b1;
        tick();
        checks++;
        if ({iss_pay_o, count_o} !== {32'd201, 4'd1}) begin
            errors++;
            $display("FAIL stall_next got pay=%0d cnt=%0d exp pay=201 cnt=1", iss_pay_o, count_o);
        end
        tick();
        iss_ready_i = 1'b0;
    endtask

    task automatic test_random();
        int   s;
        ent_t e;
        logic [1+3*PREG_W+1+PAY_W-1:0] exp_iss;
        for (int c = 0; c < 1500; c++) begin
            s = m_sel();
            if (s >= 0) begin
                e = mq[s];
                exp_iss = {1'b1, e.rs1, e.rs2, e.rdv, e.rd, e.pay};
            end else begin
                exp_iss = '0;
            end
            checks++;
            if ({iss_valid_o, iss_rs1_idx_o, iss_rs2_idx_o, iss_rd_v_o, iss_rd_idx_o, iss_pay_o} !== exp_iss) begin
                errors++;
                $display("FAIL rand_issue cyc=%0d got v=%b pay=%h rd=%0d exp %h", c, iss_valid_o, iss_pay_o, iss_rd_idx_o, exp_iss);
            end
            checks++;
            if ({count_o, in_ready_o} !== {CNT_W'(mq.size()), mq.size() < DEPTH}) begin
                errors++;
                $display("FAIL rand_count cyc=%0d got cnt=%0d rdy=%b exp cnt=%0d", c, count_o, in_ready_o, mq.size());
            end
            set_in($urandom_range(0, 9) < 7, $urandom_range(0, 4) != 0, $urandom_range(0, 7),
                   $urandom_range(0, 9) < 3, $urandom_range(0, 4) != 0, $urandom_range(0, 7),
                   $urandom_range(0, 9) < 3, $urandom_range(0, 1), $urandom_range(0, 63), $urandom);
            wb_valid_i  = $urandom_range(0, 1);
            wb_idx_i    = PREG_W'($urandom_range(0, 7));
            iss_ready_i = $urandom_range(0, 9) < 4;
            flush_i     = $urandom_range(0, 99) < 2;
            tick();
        end
        set_in(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        wb_valid_i = 1'b0; iss_ready_i = 1'b0; flush_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_order();
        test_bypass();
        test_full();
        test_flush();
        test_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
